axi_ifetch_master: RTL and testbench
====================================

Name: axi_ifetch_master

Overview:
- AXI4 read-only master that turns instruction-fetch requests from the core into INCR read bursts towards the instruction ROM slave.
- Returns fetched words to the core through a small FIFO, with back-pressure, flush/abort and 4KB-boundary splitting.
- Sits directly upstream of the instruction ROM slave on the instruction-side interconnect port.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; fixed 32 in this revision, beat = 4 bytes.
- ID_WIDTH, 4, AXI ID width.
- MASTER_ID, 0, constant value driven on M_AXI_arid.
- FIFO_DEPTH, 4, return FIFO entries; power of two, ≥2.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  async active-high reset.
- fetch_valid  in  1  request valid.
- fetch_ready  out  1  request accepted when valid&&ready.
- fetch_addr  in  ADDR_WIDTH  start byte address; bits[1:0] ignored.
- fetch_len  in  8  words minus 1 (0..255).
- flush  in  1  abort current fetch, discard buffered/in-flight data.
- instr_valid  out  1  word available.
- instr_ready  in  1  core consumes word.
- instr_data  out  DATA_WIDTH  fetched word.
- instr_addr  out  ADDR_WIDTH  byte address of instr_data.
- instr_err  out  1  RRESP != OKAY for this word.
- busy  out  1  state != IDLE or FIFO non-empty.
- proto_err  out  1  sticky protocol-violation flag.
- M_AXI_arid  out  ID_WIDTH  = MASTER_ID.
- M_AXI_araddr  out  ADDR_WIDTH  burst start, word aligned.
- M_AXI_arlen  out  8  beats-1.
- M_AXI_arsize  out  3  constant 3'b010.
- M_AXI_arburst  out  2  constant 2'b01 (INCR).
- M_AXI_arlock  out  2  constant 0.
- M_AXI_arcache  out  4  constant 0.
- M_AXI_arprot  out  3  constant 3'b100 (instruction).
- M_AXI_arqos  out  4  constant 0.
- M_AXI_arregion  out  4  constant 0.
- M_AXI_arvalid  out  1  address valid.
- M_AXI_arready  in  1  address accepted.
- M_AXI_rid  in  ID_WIDTH  read ID.
- M_AXI_rdata  in  DATA_WIDTH  read data.
- M_AXI_rresp  in  2  read response.
- M_AXI_rlast  in  1  last beat.
- M_AXI_rvalid  in  1  beat valid.
- M_AXI_rready  out  1  beat accepted.

Behaviour:
- Reset: all outputs 0 except the constant AR fields; arid = MASTER_ID; FIFO empty; state IDLE; proto_err cleared.
- Reset mid-burst: everything returns to reset values immediately, regardless of outstanding beats.
- Single outstanding burst only.

States: IDLE, ADDR, DATA, DRAIN.
- IDLE: fetch_ready = 1 when flush = 0 and the FIFO is empty.
  - On accept, latch the word-aligned address and remaining = fetch_len+1.
  - Compute the beat count: min(remaining, words to the next 4KB boundary).
  - Go to ADDR. arvalid asserts in the cycle after accept.
- ADDR: araddr/arlen held stable while arvalid && !arready.
  - On handshake: arvalid drops next cycle, go to DATA.
  - Beat counter loads arlen.
- DATA: rready = (FIFO count < FIFO_DEPTH), using the registered count; a same-cycle pop does not raise rready.
  - Each accepted beat pushes {rdata, word address, rresp!=0} into the FIFO and advances the address by 4.
  - On the beat with rlast:
    - If total words remain (4KB split), recompute the next burst and go to ADDR.
    - Otherwise go to IDLE.
- DRAIN: rready = 1, beats discarded, exit to IDLE on rlast.
- proto_err set (sticky) on any of:
  - rlast on a beat other than the expected last;
  - expected last beat without rlast (treated as last anyway);
  - rid != MASTER_ID;
  - rvalid while in IDLE or ADDR.
- Flush:
  - FIFO cleared at the clock edge; instr_valid = 0 the next cycle.
  - IDLE: stay; fetch_valid in the same cycle is not accepted.
  - ADDR: arvalid stays asserted until the handshake (no AXI retraction), then DRAIN; a second split burst is not issued.
  - DATA: go to DRAIN; the push in the same cycle is discarded.
  - DRAIN: no effect.
- FIFO: instr_* driven from the FIFO head. Push and pop in the same cycle are allowed when not full. Latency from R handshake to instr_valid is 1 cycle.
- Address arithmetic: modulo 2^ADDR_WIDTH; 4KB splitting guarantees that no burst crosses a boundary.

Test Plan:
- fetch_addr=0x100, len=3, arready immediate, rready held -> one AR (araddr 0x100, arlen 3); instr words at 0x100..0x10C in order; instr_err=0; busy drops after the last pop.
- fetch_addr=0xFF8, len=3 -> two ARs: (0xFF8, arlen 1) then (0x1000, arlen 1); four words with contiguous instr_addr.
- instr_ready=0, len=7, FIFO_DEPTH=4 -> rready low after 4 pushes; no beat lost; resume on pop; all 8 words correct.
- flush while arvalid=1, arready held low 5 cycles -> arvalid stays high until the handshake; all beats accepted with rready=1 and discarded; instr_valid stays 0; return to IDLE after rlast.
- Slave returns rresp=2'b10 on beat 2 of 4 -> instr_err=1 on that word only; rlast early on beat 1 of 4 -> proto_err=1 and stays set until ARESET.

Source files
------------

// File: rtl/axi_ifetch_master.sv
// AXI4 read-only instruction-fetch master: turns core fetch requests into INCR
// bursts split at 4KB boundaries and returns words through a small FIFO.
module axi_ifetch_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MASTER_ID  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic [7:0]            fetch_len,
  input  logic                  flush,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_err,
  output logic                  busy,
  output logic                  proto_err,
  output logic [ID_WIDTH-1:0]   M_AXI_arid,
  output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
  output logic [7:0]            M_AXI_arlen,
  output logic [2:0]            M_AXI_arsize,
  output logic [1:0]            M_AXI_arburst,
  output logic [1:0]            M_AXI_arlock,
  output logic [3:0]            M_AXI_arcache,
  output logic [2:0]            M_AXI_arprot,
  output logic [3:0]            M_AXI_arqos,
  output logic [3:0]            M_AXI_arregion,
  output logic                  M_AXI_arvalid,
  input  logic                  M_AXI_arready,
  input  logic [ID_WIDTH-1:0]   M_AXI_rid,
  input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
  input  logic [1:0]            M_AXI_rresp,
  input  logic                  M_AXI_rlast,
  input  logic                  M_AXI_rvalid,
  output logic                  M_AXI_rready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [8:0]            remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  arvalid_q, arvalid_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  flush_seen_q, flush_seen_d;
  logic                  proto_err_q, proto_err_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_err_q, fifo_err_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  fetch_ready_c, rready_c, beat, beat_last, push, pop;
  logic [ADDR_WIDTH-1:0] fetch_aligned;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^fetch_addr[1:0];
  assign fetch_aligned    = {fetch_addr[ADDR_WIDTH-1:2], 2'b00};

  // Beats in the next burst: whatever remains, clipped at the next 4KB page.
  function automatic logic [7:0] burst_len(input logic [9:0] word_idx, input logic [8:0] rem);
    logic [10:0] to_bnd;
    logic [10:0] beats;
    to_bnd = 11'd1024 - {1'b0, word_idx};
    beats  = ({2'b00, rem} <= to_bnd) ? {2'b00, rem} : to_bnd;
    return 8'(beats - 11'd1);
  endfunction

  always_comb begin
    state_d       = state_q;
    next_addr_d   = next_addr_q;
    remaining_d   = remaining_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    arvalid_d     = arvalid_q;
    beat_cnt_d    = beat_cnt_q;
    flush_seen_d  = flush_seen_q;
    proto_err_d   = proto_err_q;
    fetch_ready_c = 1'b0;
    rready_c      = 1'b0;
    beat_last     = 1'b0;
    push          = 1'b0;

    case (state_q)
      IDLE: begin
        fetch_ready_c = !flush && (count_q == '0);
        if (M_AXI_rvalid) proto_err_d = 1'b1;
        if (fetch_valid && fetch_ready_c) begin
          next_addr_d  = fetch_aligned;
          remaining_d  = {1'b0, fetch_len} + 9'd1;
          araddr_d     = fetch_aligned;
          arlen_d      = burst_len(fetch_aligned[11:2], {1'b0, fetch_len} + 9'd1);
          arvalid_d    = 1'b1;
          flush_seen_d = 1'b0;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (M_AXI_rvalid) proto_err_d = 1'b1;
        if (flush) flush_seen_d = 1'b1;
        // The address is never retracted; a flush only redirects the data to DRAIN.
        if (arvalid_q && M_AXI_arready) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = arlen_q;
          state_d    = (flush || flush_seen_q) ? DRAIN : DATA;
        end
      end
      DATA:    rready_c = (count_q < CNT_W'(FIFO_DEPTH));
      DRAIN:   rready_c = 1'b1;
      default: state_d = IDLE;
    endcase

    beat = rready_c && M_AXI_rvalid;
    if (beat) begin
      beat_last = M_AXI_rlast || (beat_cnt_q == 8'd0);
      if ((M_AXI_rlast && beat_cnt_q != 8'd0) || (!M_AXI_rlast && beat_cnt_q == 8'd0) ||
          (M_AXI_rid != ID_WIDTH'(MASTER_ID)))
        proto_err_d = 1'b1;
      beat_cnt_d  = beat_cnt_q - 8'd1;
      next_addr_d = next_addr_q + ADDR_WIDTH'(4);
      remaining_d = remaining_q - 9'd1;
      push        = (state_q == DATA) && !flush;
    end

    if (state_q == DATA) begin
      if (beat && beat_last) begin
        if (!flush && remaining_d != 9'd0) begin
          araddr_d     = next_addr_d;
          arlen_d      = burst_len(next_addr_d[11:2], remaining_d);
          arvalid_d    = 1'b1;
          flush_seen_d = 1'b0;
          state_d      = ADDR;
        end else begin
          state_d = IDLE;
        end
      end else if (flush) begin
        state_d = DRAIN;
      end
    end else if (state_q == DRAIN && beat && beat_last) begin
      state_d = IDLE;
    end
  end

  // Return FIFO; a flush empties it at the edge and drops any same-cycle push.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop         = (count_q != '0) && instr_ready;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_data_d[wr_ptr_q] = M_AXI_rdata;
        fifo_addr_d[wr_ptr_q] = next_addr_q;
        fifo_err_d[wr_ptr_q]  = (M_AXI_rresp != 2'b00);
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      next_addr_q  <= '0;
      remaining_q  <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      beat_cnt_q   <= '0;
      flush_seen_q <= 1'b0;
      proto_err_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
      fifo_err_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      remaining_q  <= remaining_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arvalid_q    <= arvalid_d;
      beat_cnt_q   <= beat_cnt_d;
      flush_seen_q <= flush_seen_d;
      proto_err_q  <= proto_err_d;
      fifo_data_q  <= fifo_data_d;
      fifo_addr_q  <= fifo_addr_d;
      fifo_err_q   <= fifo_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign fetch_ready    = fetch_ready_c;
  assign M_AXI_rready   = rready_c;
  assign instr_valid    = (count_q != '0);
  assign instr_data     = fifo_data_q[rd_ptr_q];
  assign instr_addr     = fifo_addr_q[rd_ptr_q];
  assign instr_err      = fifo_err_q[rd_ptr_q];
  assign busy           = (state_q != IDLE) || (count_q != '0);
  assign proto_err      = proto_err_q;
  assign M_AXI_arid     = ID_WIDTH'(MASTER_ID);
  assign M_AXI_araddr   = araddr_q;
  assign M_AXI_arlen    = arlen_q;
  assign M_AXI_arvalid  = arvalid_q;
  assign M_AXI_arsize   = 3'b010;
  assign M_AXI_arburst  = 2'b01;
  assign M_AXI_arlock   = 2'b00;
  assign M_AXI_arcache  = 4'b0000;
  assign M_AXI_arprot   = 3'b100;
  assign M_AXI_arqos    = 4'b0000;
  assign M_AXI_arregion = 4'b0000;

endmodule

// File: tb/tb_axi_ifetch_master.sv
// Scoreboard bench for axi_ifetch_master: a reactive ROM slave model serves
// whatever bursts are issued, and fetched words are compared against a queue.
module tb_axi_ifetch_master;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_addr = '0;
  logic [7:0]  fetch_len = '0;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;
  logic        instr_err;
  logic        busy;
  logic        proto_err;
  logic [3:0]  M_AXI_arid;
  logic [31:0] M_AXI_araddr;
  logic [7:0]  M_AXI_arlen;
  logic [2:0]  M_AXI_arsize;
  logic [1:0]  M_AXI_arburst;
  logic [1:0]  M_AXI_arlock;
  logic [3:0]  M_AXI_arcache;
  logic [2:0]  M_AXI_arprot;
  logic [3:0]  M_AXI_arqos;
  logic [3:0]  M_AXI_arregion;
  logic        M_AXI_arvalid;
  logic        M_AXI_arready = 1'b0;
  logic [3:0]  M_AXI_rid = '0;
  logic [31:0] M_AXI_rdata = '0;
  logic [1:0]  M_AXI_rresp = '0;
  logic        M_AXI_rlast = 1'b0;
  logic        M_AXI_rvalid = 1'b0;
  logic        M_AXI_rready;

  axi_ifetch_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .fetch_len(fetch_len), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_addr(instr_addr), .instr_err(instr_err),
    .busy(busy), .proto_err(proto_err),
    .M_AXI_arid(M_AXI_arid), .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen),
    .M_AXI_arsize(M_AXI_arsize), .M_AXI_arburst(M_AXI_arburst), .M_AXI_arlock(M_AXI_arlock),
    .M_AXI_arcache(M_AXI_arcache), .M_AXI_arprot(M_AXI_arprot), .M_AXI_arqos(M_AXI_arqos),
    .M_AXI_arregion(M_AXI_arregion), .M_AXI_arvalid(M_AXI_arvalid),
    .M_AXI_arready(M_AXI_arready), .M_AXI_rid(M_AXI_rid), .M_AXI_rdata(M_AXI_rdata),
    .M_AXI_rresp(M_AXI_rresp), .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid),
    .M_AXI_rready(M_AXI_rready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } word_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  word_t exp_q[$];
  ar_t   exp_ar[$];
  ar_t   pend[$];

  int          total_cnt = 0;
  int          bad_cnt = 0;
  int          ar_hold = 0;
  bit          ar_check_en = 1'b1;
  logic [31:0] err_addr = 32'h1;
  bit          early_en = 1'b0;
  int          early_idx = 0;
  int          beat_idx = 0;
  int          rbeats_total = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wordOf(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // ROM slave model: samples handshakes at negedge, updates just after posedge.
  initial begin : slave
    logic        ar_hs, r_hs, r_last;
    ar_t         cur, e;
    logic [31:0] a;
    forever begin
      @(negedge ACLK);
      ar_hs    = M_AXI_arvalid && M_AXI_arready;
      r_hs     = M_AXI_rvalid && M_AXI_rready;
      r_last   = M_AXI_rlast;
      cur.addr = M_AXI_araddr;
      cur.len  = M_AXI_arlen;
      @(posedge ACLK);
      #1;
      if (ARESET) begin
        pend.delete();
        beat_idx      = 0;
        M_AXI_rvalid  = 1'b0;
        M_AXI_rlast   = 1'b0;
        M_AXI_arready = (ar_hold == 0);
        continue;
      end
      if (ar_hs) begin
        pend.push_back(cur);
        if (ar_check_en) begin
          if (exp_ar.size() == 0) checkOutput("ar_pending", 64'(exp_ar.size()), 64'd1);
          else begin
            e = exp_ar.pop_front();
            checkOutput("araddr", 64'(cur.addr), 64'(e.addr));
            checkOutput("arlen", 64'(cur.len), 64'(e.len));
          end
        end
      end
      if (r_hs) begin
        rbeats_total++;
        if (r_last) begin
          if (pend.size() > 0) void'(pend.pop_front());
          beat_idx = 0;
          early_en = 1'b0;
        end else beat_idx++;
      end
      if (M_AXI_arvalid && ar_hold > 0) ar_hold--;
      M_AXI_arready = (ar_hold == 0);
      if (pend.size() > 0) begin
        a            = pend[0].addr + 32'(4 * beat_idx);
        M_AXI_rvalid = 1'b1;
        M_AXI_rdata  = wordOf(a);
        M_AXI_rresp  = (a == err_addr) ? 2'b10 : 2'b00;
        M_AXI_rlast  = (beat_idx == int'(pend[0].len)) || (early_en && beat_idx == early_idx);
      end else begin
        M_AXI_rvalid = 1'b0;
        M_AXI_rlast  = 1'b0;
      end
    end
  end

  // Output monitor: every word the core consumes must match the scoreboard head.
  initial begin : monitor
    word_t w;
    forever begin
      @(negedge ACLK);
      if (!ARESET && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) checkOutput("word_pending", 64'(exp_q.size()), 64'd1);
        else begin
          w = exp_q.pop_front();
          checkOutput("instr_addr", 64'(instr_addr), 64'(w.addr));
          checkOutput("instr_data", 64'(instr_data), 64'(w.data));
          checkOutput("instr_err", 64'(instr_err), 64'(w.err));
        end
      end
    end
  end

  // Drives one fetch request and pushes the expected bursts and words.
  task automatic applyStimulus(input logic [31:0] addr, input int len, input bit expect_words,
                               input int max_ars);
    logic [31:0] a;
    int          rem, tob, b, n, off;
    bit          accepted;
    word_t       w;
    ar_t         e;
    a   = {addr[31:2], 2'b00};
    rem = len + 1;
    n   = 0;
    while (rem > 0) begin
      off = int'(a[11:0]);
      tob = (4096 - off) / 4;
      b   = (rem < tob) ? rem : tob;
      if (n < max_ars) begin
        e.addr = a;
        e.len  = 8'(b - 1);
        exp_ar.push_back(e);
      end
      n++;
      a   = a + 32'(4 * b);
      rem = rem - b;
    end
    if (expect_words) begin
      for (int i = 0; i <= len; i++) begin
        w.addr = {addr[31:2], 2'b00} + 32'(4 * i);
        w.data = wordOf(w.addr);
        w.err  = (w.addr == err_addr);
        exp_q.push_back(w);
      end
    end
    @(posedge ACLK);
    #1;
    fetch_valid = 1'b1;
    fetch_addr  = addr;
    fetch_len   = 8'(len);
    accepted    = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge ACLK);
      if (fetch_ready) accepted = 1'b1;
      @(posedge ACLK);
      #1;
    end
    fetch_valid = 1'b0;
    if (!accepted) checkOutput("fetch_accept", 64'(fetch_ready), 64'd1);
  endtask

  task automatic waitDone(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge ACLK);
      if (exp_q.size() == 0 && pend.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) checkOutput("done_timeout", {busy, exp_q.size() != 0, pend.size() != 0}, 64'd0);
    checkOutput("ars_left", 64'(exp_ar.size()), 64'd0);
    checkOutput("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int  base;
    bit  hs, drop;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("rst_instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_arvalid", 64'(M_AXI_arvalid), 64'd0);
    checkOutput("rst_rready", 64'(M_AXI_rready), 64'd0);
    checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
    checkOutput("rst_araddr", 64'(M_AXI_araddr), 64'd0);
    checkOutput("rst_arid", 64'(M_AXI_arid), 64'd0);
    checkOutput("rst_arsize", 64'(M_AXI_arsize), 64'd2);
    checkOutput("rst_arburst", 64'(M_AXI_arburst), 64'd1);
    checkOutput("rst_arprot", 64'(M_AXI_arprot), 64'd4);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    $display("[TB] simple burst");
    applyStimulus(32'h100, 3, 1'b1, 99);
    waitDone(100);

    $display("[TB] 4KB split");
    applyStimulus(32'hFF8, 3, 1'b1, 99);
    waitDone(100);

    $display("[TB] back-pressure");
    instr_ready = 1'b0;
    base = rbeats_total;
    applyStimulus(32'h200, 7, 1'b1, 99);
    repeat (15) @(negedge ACLK);
    checkOutput("beats_when_full", 64'(rbeats_total - base), 64'd4);
    checkOutput("rready_full", 64'(M_AXI_rready), 64'd0);
    checkOutput("instr_valid_full", 64'(instr_valid), 64'd1);
    @(posedge ACLK);
    #1;
    instr_ready = 1'b1;
    waitDone(200);

    $display("[TB] flush with buffered words");
    instr_ready = 1'b0;
    applyStimulus(32'h400, 1, 1'b0, 99);
    repeat (8) @(negedge ACLK);
    checkOutput("buffered_valid", 64'(instr_valid), 64'd1);
    @(posedge ACLK);
    #1;
    flush = 1'b1;
    @(posedge ACLK);
    #1;
    flush = 1'b0;
    @(negedge ACLK);
    checkOutput("flushed_valid", 64'(instr_valid), 64'd0);
    checkOutput("flushed_busy", 64'(busy), 64'd0);
    instr_ready = 1'b1;

    $display("[TB] flush during address phase");
    ar_hold = 5;
    base    = rbeats_total;
    applyStimulus(32'hFF8, 3, 1'b0, 1);
    flush = 1'b1;
    @(posedge ACLK);
    #1;
    flush = 1'b0;
    hs    = 1'b0;
    drop  = 1'b0;
    for (int i = 0; i < 20 && !hs && !drop; i++) begin
      @(negedge ACLK);
      if (M_AXI_arvalid && M_AXI_arready) hs = 1'b1;
      else if (!M_AXI_arvalid) drop = 1'b1;
    end
    checkOutput("arvalid_held", 64'(drop), 64'd0);
    checkOutput("ar_handshake", 64'(hs), 64'd1);
    waitDone(100);
    checkOutput("drained_beats", 64'(rbeats_total - base), 64'd2);
    checkOutput("proto_after_drain", 64'(proto_err), 64'd0);

    $display("[TB] flush blocks request in IDLE");
    @(posedge ACLK);
    #1;
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h800;
    fetch_len   = 8'd0;
    @(negedge ACLK);
    checkOutput("fetch_ready_flush", 64'(fetch_ready), 64'd0);
    @(posedge ACLK);
    #1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    @(negedge ACLK);
    checkOutput("not_accepted_busy", 64'(busy), 64'd0);
    checkOutput("not_accepted_arvalid", 64'(M_AXI_arvalid), 64'd0);

    $display("[TB] error response on one beat");
    err_addr = 32'h504;
    applyStimulus(32'h500, 3, 1'b1, 99);
    waitDone(100);
    err_addr = 32'h1;
    checkOutput("proto_clean", 64'(proto_err), 64'd0);

    $display("[TB] early rlast");
    early_en    = 1'b1;
    early_idx   = 1;
    ar_check_en = 1'b0;
    applyStimulus(32'h600, 3, 1'b1, 0);
    waitDone(100);
    ar_check_en = 1'b1;
    checkOutput("proto_early_last", 64'(proto_err), 64'd1);
    applyStimulus(32'h700, 1, 1'b1, 99);
    waitDone(100);
    checkOutput("proto_sticky", 64'(proto_err), 64'd1);

    $display("[TB] reset mid-burst");
    applyStimulus(32'h900, 15, 1'b1, 99);
    repeat (4) @(negedge ACLK);
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    exp_q.delete();
    exp_ar.delete();
    @(negedge ACLK);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_valid", 64'(instr_valid), 64'd0);
    checkOutput("midrst_arvalid", 64'(M_AXI_arvalid), 64'd0);
    checkOutput("midrst_rready", 64'(M_AXI_rready), 64'd0);
    checkOutput("midrst_proto", 64'(proto_err), 64'd0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (2) @(posedge ACLK);

    $display("[TB] recovery fetch");
    applyStimulus(32'hA00, 2, 1'b1, 99);
    waitDone(100);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
